// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, arbiter
// state type and default timing.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   localparam int DEF_REF_PERIOD = 750;
   localparam int DEF_TIMEOUT    = 1023;
   localparam int DEF_ADDR_W     = 12;
   localparam int DEF_BA_W       = 2;
   localparam int DEF_DQ_W       = 16;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_ARBIT,
      ST_AREF,
      ST_WRITE,
      ST_READ
   } arb_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh-interval timer: raises ref_pending every REF_PERIOD cycles once
// initialisation is done, and latches ref_overrun if a request is not taken in time.
module sdram_ref_timer
   import sdram_pkg::*;
#(
   parameter int REF_PERIOD = DEF_REF_PERIOD
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic run,
   input  logic ref_ack,
   output logic ref_pending,
   output logic ref_overrun
);

   localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
   localparam logic [CW-1:0] TERM = CW'(REF_PERIOD - 1);

   logic [CW-1:0] ref_cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ref_cnt     <= '0;
         ref_pending <= 1'b0;
         ref_overrun <= 1'b0;
      end else if (!run) begin
         ref_cnt <= '0;
      end else if (ref_cnt == TERM) begin
         ref_cnt     <= '0;
         ref_pending <= 1'b1;
         // an ack on this very edge means the previous request is being served
         if (ref_pending && !ref_ack)
            ref_overrun <= 1'b1;
      end else begin
         ref_cnt <= ref_cnt + CW'(1);
         if (ref_ack)
            ref_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: passes the init engine through, then grants the
// bus to refresh, write or read engines one at a time.
//
//   state | meaning
//   INIT  | init engine owns the bus until init_done
//   ARBIT | bus idle (NOP), choose next engine
//   AREF  | refresh engine granted (ar_en)
//   WRITE | write engine granted (wr_en), drives DQ
//   READ  | read engine granted (rd_en)
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int REF_PERIOD = DEF_REF_PERIOD,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int BA_W       = DEF_BA_W,
   parameter int DQ_W       = DEF_DQ_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_done,
   input  logic [3:0]        init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [3:0]        ar_cmd,
   input  logic [BA_W-1:0]   ar_ba,
   input  logic [ADDR_W-1:0] ar_addr,
   input  logic              ar_end,
   output logic              ar_en,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DQ_W-1:0]   wr_data,
   input  logic              wr_data_oe,
   input  logic              wr_end,
   output logic              wr_en,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_end,
   output logic              rd_en,
   output logic [3:0]        sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DQ_W-1:0]   sdram_dq_out,
   output logic              sdram_dq_oe,
   output logic              ref_overrun,
   output logic              timeout_err
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

   arb_state_t      state;
   logic [TO_W-1:0] grant_cnt;
   logic            last_was_write;
   logic            ref_pending;
   logic            ref_ack;
   logic            eng_end;
   logic            grant_expired;

   assign ref_ack = (state == ST_ARBIT) && ref_pending;
   assign eng_end = ((state == ST_AREF)  && ar_end) ||
                    ((state == ST_WRITE) && wr_end) ||
                    ((state == ST_READ)  && rd_end);
   assign grant_expired = (grant_cnt == '0);

   sdram_ref_timer #(
      .REF_PERIOD (REF_PERIOD)
   ) u_ref_timer (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .run         (init_done),
      .ref_ack     (ref_ack),
      .ref_pending (ref_pending),
      .ref_overrun (ref_overrun)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state          <= ST_INIT;
         ar_en          <= 1'b0;
         wr_en          <= 1'b0;
         rd_en          <= 1'b0;
         last_was_write <= 1'b0;
         grant_cnt      <= '0;
         timeout_err    <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_done)
                  state <= ST_ARBIT;
            end
            ST_ARBIT: begin
               grant_cnt <= TO_LOAD;
               if (ref_pending) begin
                  state <= ST_AREF;
                  ar_en <= 1'b1;
               end else if (wr_req && (!rd_req || !last_was_write)) begin
                  state          <= ST_WRITE;
                  wr_en          <= 1'b1;
                  last_was_write <= 1'b1;
               end else if (rd_req) begin
                  state          <= ST_READ;
                  rd_en          <= 1'b1;
                  last_was_write <= 1'b0;
               end
            end
            ST_AREF, ST_WRITE, ST_READ: begin
               // a timeout releases the bus exactly like a normal end
               if (eng_end || grant_expired) begin
                  state <= ST_ARBIT;
                  ar_en <= 1'b0;
                  wr_en <= 1'b0;
                  rd_en <= 1'b0;
                  if (!eng_end)
                     timeout_err <= 1'b1;
               end else begin
                  grant_cnt <= grant_cnt - TO_W'(1);
               end
            end
            default: begin
               state <= ST_INIT;
               ar_en <= 1'b0;
               wr_en <= 1'b0;
               rd_en <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      sdram_cmd    = CMD_NOP;
      sdram_ba     = '0;
      sdram_addr   = '0;
      sdram_dq_out = '0;
      sdram_dq_oe  = 1'b0;
      case (state)
         ST_INIT: begin
            sdram_cmd  = init_cmd;
            sdram_ba   = init_ba;
            sdram_addr = init_addr;
         end
         ST_AREF: begin
            sdram_cmd  = ar_cmd;
            sdram_ba   = ar_ba;
            sdram_addr = ar_addr;
         end
         ST_WRITE: begin
            sdram_cmd    = wr_cmd;
            sdram_ba     = wr_ba;
            sdram_addr   = wr_addr;
            sdram_dq_out = wr_data;
            sdram_dq_oe  = wr_data_oe;
         end
         ST_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_ba   = rd_ba;
            sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant table plus refresh, timeout,
// overrun and reset sequences on a cycle schedule counted from init_done.
module tb_sdram_arbiter;

   localparam logic [3:0]  I_CMD = 4'b0010, A_CMD = 4'b0001, W_CMD = 4'b0100;
   localparam logic [3:0]  R_CMD = 4'b0101, NOP   = 4'b0111;
   localparam logic [1:0]  I_BA = 2'd1, A_BA = 2'd0, W_BA = 2'd2, R_BA = 2'd3;
   localparam logic [11:0] I_AD = 12'h400, A_AD = 12'h0AA, W_AD = 12'h123, R_AD = 12'h321;
   localparam logic [15:0] W_DATA = 16'hA5C3;

   logic        sys_clk = 1'b0;
   logic        sys_rst, init_done;
   logic [3:0]  init_cmd, ar_cmd, wr_cmd, rd_cmd, sdram_cmd;
   logic [1:0]  init_ba, ar_ba, wr_ba, rd_ba, sdram_ba;
   logic [11:0] init_addr, ar_addr, wr_addr, rd_addr, sdram_addr;
   logic [15:0] wr_data, sdram_dq_out;
   logic        ar_end, ar_en, wr_req, wr_data_oe, wr_end, wr_en;
   logic        rd_req, rd_end, rd_en, sdram_dq_oe, ref_overrun, timeout_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   sdram_arbiter dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .ar_cmd(ar_cmd), .ar_ba(ar_ba), .ar_addr(ar_addr), .ar_end(ar_end), .ar_en(ar_en),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_data_oe(wr_data_oe), .wr_end(wr_end), .wr_en(wr_en),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .rd_end(rd_end), .rd_en(rd_en),
      .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
      .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
      .ref_overrun(ref_overrun), .timeout_err(timeout_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic wr_req, rd_req, wr_end, rd_end, ar_end, oe;
      logic x_wr, x_rd, x_oe;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // expected bus contents follow from which grant is expected to be active
   task automatic check_bus(input string tag, input logic x_ar, input logic x_wr,
                            input logic x_rd, input logic x_oe);
      logic [3:0]  e_cmd;
      logic [1:0]  e_ba;
      logic [11:0] e_ad;
      e_cmd = NOP; e_ba = 2'd0; e_ad = 12'h000;
      if (x_ar) begin e_cmd = A_CMD; e_ba = A_BA; e_ad = A_AD; end
      if (x_wr) begin e_cmd = W_CMD; e_ba = W_BA; e_ad = W_AD; end
      if (x_rd) begin e_cmd = R_CMD; e_ba = R_BA; e_ad = R_AD; end
      chk({tag, ".ar_en"}, 32'(ar_en), 32'(x_ar));
      chk({tag, ".wr_en"}, 32'(wr_en), 32'(x_wr));
      chk({tag, ".rd_en"}, 32'(rd_en), 32'(x_rd));
      chk({tag, ".cmd"},   32'(sdram_cmd), 32'(e_cmd));
      chk({tag, ".ba"},    32'(sdram_ba), 32'(e_ba));
      chk({tag, ".addr"},  32'(sdram_addr), 32'(e_ad));
      chk({tag, ".dq_oe"}, 32'(sdram_dq_oe), 32'(x_oe));
      chk({tag, ".dq_out"}, 32'(sdram_dq_out), x_wr ? 32'(W_DATA) : 32'd0);
   endtask

   initial begin
      //          wr rd we re ae oe | xw xr xoe
      vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1};
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0};
      vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0};
      vecs[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1};
      vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1};
      vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0};

      sys_rst = 1'b1; init_done = 1'b0;
      init_cmd = I_CMD; init_ba = I_BA; init_addr = I_AD;
      ar_cmd = A_CMD;   ar_ba = A_BA;   ar_addr = A_AD;
      wr_cmd = W_CMD;   wr_ba = W_BA;   wr_addr = W_AD;   wr_data = W_DATA;
      rd_cmd = R_CMD;   rd_ba = R_BA;   rd_addr = R_AD;
      ar_end = 1'b0; wr_req = 1'b0; wr_data_oe = 1'b0; wr_end = 1'b0;
      rd_req = 1'b0; rd_end = 1'b0;
      tick(); tick();
      sys_rst = 1'b0;

      chk("rst.cmd", 32'(sdram_cmd), 32'(I_CMD));
      chk("rst.en", 32'({ar_en, wr_en, rd_en}), 32'd0);
      chk("rst.dq", 32'({sdram_dq_oe, sdram_dq_out}), 32'd0);
      chk("rst.flags", 32'({ref_overrun, timeout_err}), 32'd0);

      // requests during init must be ignored
      wr_req = 1'b1;
      repeat (20) tick();
      wr_req = 1'b0;
      chk("init.cmd", 32'(sdram_cmd), 32'(I_CMD));
      chk("init.ba", 32'(sdram_ba), 32'(I_BA));
      chk("init.addr", 32'(sdram_addr), 32'(I_AD));
      chk("init.en", 32'({ar_en, wr_en, rd_en}), 32'd0);

      init_done = 1'b1;
      cyc = 0;
      tick();
      check_bus("arbit0", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         wr_req = vecs[i].wr_req; rd_req = vecs[i].rd_req;
         wr_end = vecs[i].wr_end; rd_end = vecs[i].rd_end;
         ar_end = vecs[i].ar_end; wr_data_oe = vecs[i].oe;
         tick();
         check_bus($sformatf("vec%0d", i), 1'b0, vecs[i].x_wr, vecs[i].x_rd, vecs[i].x_oe);
      end
      wr_req = 1'b0; rd_req = 1'b0; wr_end = 1'b0; rd_end = 1'b0; ar_end = 1'b0;
      wr_data_oe = 1'b1;

      // first refresh grant
      while (!ar_en && cyc < 800) tick();
      chk("ref1.rise_cyc", 32'(cyc), 32'd751);
      check_bus("ref1", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) tick();
      chk("ref1.hold", 32'(ar_en), 32'd1);
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_bus("ref1.end", 1'b0, 1'b0, 1'b0, 1'b0);

      // second refresh expires with a write also waiting: refresh wins
      wait_until(1500);
      chk("ref2.not_yet", 32'(ar_en), 32'd0);
      wr_req = 1'b1;
      tick();
      check_bus("ref2.prio", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_bus("ref2.gap", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_bus("wr_after_ref", 1'b0, 1'b1, 1'b0, 1'b1);
      wr_req = 1'b0;

      // refresh expiring mid-write waits for wr_end
      wait_until(2252);
      check_bus("ref3.wait", 1'b0, 1'b1, 1'b0, 1'b1);
      wait_until(2259);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      check_bus("ref3.gap", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ref3.grant", 32'(ar_en), 32'd1);
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      chk("ref3.end", 32'(ar_en), 32'd0);

      // a write that never ends: overrun while holding, then timeout
      wait_until(2989);
      wr_req = 1'b1;
      tick();
      chk("long.grant", 32'(wr_en), 32'd1);
      wr_req = 1'b0;
      wait_until(3749);
      chk("overrun.before", 32'(ref_overrun), 32'd0);
      tick();
      chk("overrun.set", 32'(ref_overrun), 32'd1);
      wait_until(4012);
      chk("timeout.before_en", 32'(wr_en), 32'd1);
      chk("timeout.before_err", 32'(timeout_err), 32'd0);
      tick();
      chk("timeout.en_drop", 32'(wr_en), 32'd0);
      chk("timeout.err", 32'(timeout_err), 32'd1);
      tick();
      chk("timeout.ref_next", 32'(ar_en), 32'd1);
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      chk("overrun.sticky", 32'({ref_overrun, timeout_err}), 32'd3);

      // reset in the middle of a write
      wr_req = 1'b1;
      tick();
      check_bus("rstburst.pre", 1'b0, 1'b1, 1'b0, 1'b1);
      sys_rst = 1'b1;
      wr_req = 1'b0;
      tick();
      chk("rstburst.en", 32'({ar_en, wr_en, rd_en}), 32'd0);
      chk("rstburst.oe", 32'(sdram_dq_oe), 32'd0);
      chk("rstburst.dq", 32'(sdram_dq_out), 32'd0);
      chk("rstburst.flags", 32'({ref_overrun, timeout_err}), 32'd0);
      chk("rstburst.cmd", 32'(sdram_cmd), 32'(I_CMD));
      sys_rst = 1'b0;
      tick();
      chk("rstburst.rearb", 32'(sdram_cmd), 32'(NOP));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
